// File: rtl/serial_word_assembler_pkg.sv
// Shared types and parameter limits for the serial word assembler.
// Holds the receive FSM state enum and the legal parameter bounds.
package serial_word_assembler_pkg;

  localparam int unsigned MIN_BIT_CYCLES = 2;
  localparam int unsigned MAX_WIDTH      = 16;

  typedef enum logic [2:0] {
    S_BREAK,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

endpackage

// File: rtl/serial_word_assembler_if.sv
// Valid/ready word bus between the assembler output buffer and its consumer.
//   out_data  : buffered word (producer -> consumer)
//   out_valid : out_data holds an unconsumed word (producer -> consumer)
//   out_ready : consumer accepts the word at a rising edge (consumer -> producer)
interface serial_word_assembler_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/serial_word_assembler_word_out_buffer.sv
// One-entry valid/ready holding register with overrun detection.
//   clk, clr    : clock, asynchronous active-high reset
//   push_i      : a completed word is offered this cycle
//   push_data_i : the offered word
//   out_if      : valid/ready word bus toward the consumer (master side)
//   overrun_o   : one-cycle pulse when an offered word is dropped (buffer full)
module word_out_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  serial_word_assembler_if.master  out_if,
  output logic                     overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             hs_c;

  // A handshake on the same edge frees the slot, so a new word may load then.
  always_comb begin
    hs_c      = valid_q & out_if.out_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (push_i) begin
      if (!valid_q || hs_c) begin
        data_d  = push_data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (hs_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign overrun_o        = overrun_q;

endmodule

// File: rtl/serial_word_assembler.sv
// Frames a clk-synchronous start/data/stop serial stream into WIDTH-bit words
// (LSB first) and hands them to a one-entry valid/ready output buffer.
// Optional feature macro: PARITY_CHECK_EN adds an even-parity bit and the
// parity_err port.
//   clk, clr   : clock, asynchronous active-high reset
//   din        : serial input, idle high
//   out_if     : valid/ready word bus (master side)
//   frame_err  : one-cycle pulse, stop bit sampled 0
//   overrun    : one-cycle pulse, completed word dropped (buffer full)
//   parity_err : one-cycle pulse, parity mismatch (PARITY_CHECK_EN only)
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    din,
  serial_word_assembler_if.master out_if,
  output logic                    frame_err,
  output logic                    overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int unsigned HALF  = BIT_CYCLES / 2;
  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  generate
    if (BIT_CYCLES < MIN_BIT_CYCLES || (BIT_CYCLES % 2) != 0 ||
        WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_param_err
      $error("serial_word_assembler: illegal WIDTH/BIT_CYCLES");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             frame_err_q, frame_err_d;
  logic             push_c;
  logic             half_hit_c, bit_hit_c;
`ifdef PARITY_CHECK_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Receive FSM: cnt counts cycles within a bit, bit counts data bits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    sh_d        = sh_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    half_hit_c  = (cnt_q == CNT_W'(HALF - 1));
    bit_hit_c   = (cnt_q == CNT_W'(BIT_CYCLES - 1));
`ifdef PARITY_CHECK_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_BREAK: begin
        cnt_d = '0;
        if (din) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (!din) begin
          state_d = S_START;
          bit_d   = '0;
`ifdef PARITY_CHECK_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      S_START: begin
        // Mid-bit re-sample rejects glitches shorter than half a bit.
        if (half_hit_c) begin
          cnt_d   = '0;
          state_d = din ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_hit_c) begin
          cnt_d = '0;
          sh_d  = (sh_q >> 1) | (WIDTH'(din) << (WIDTH - 1));
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      S_PARITY: begin
        if (bit_hit_c) begin
          cnt_d     = '0;
          par_bad_d = (^sh_q) ^ din;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Framing error outranks parity error.
        if (bit_hit_c) begin
          cnt_d = '0;
          if (!din) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else begin
            state_d = S_IDLE;
`ifdef PARITY_CHECK_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else           push_c       = 1'b1;
`else
            push_c = 1'b1;
`endif
          end
        end
      end
      default: state_d = S_BREAK;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_BREAK;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign frame_err = frame_err_q;

  word_out_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk         (clk),
    .clr         (clr),
    .push_i      (push_c),
    .push_data_i (sh_q),
    .out_if      (out_if),
    .overrun_o   (overrun)
  );

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler (WIDTH=8, BIT_CYCLES=4).
// Edge indices are relative to edge k, the first edge that sees the start bit.
module tb_serial_word_assembler;

  localparam int W    = 8;
  localparam int BC   = 4;
  localparam int HALF = 2;
`ifdef PARITY_CHECK_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS  = W + 2 + P;
  localparam int STOP_E = HALF + BC * (W + 1 + P);

  logic clk = 1'b0;
  logic clr;
  logic din;
  logic frame_err;
  logic overrun;
`ifdef PARITY_CHECK_EN
  logic parity_err;
`endif

  serial_word_assembler_if #(.WIDTH(W)) bus ();

  serial_word_assembler #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
    .clk       (clk),
    .clr       (clr),
    .din       (din),
    .out_if    (bus),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int valid_first, valid_cnt, data_first;
  int ferr_cnt, ferr_at, ovr_cnt, ovr_at, perr_cnt, perr_at;
  int data_stop, valid_stop;

  task automatic check(input string tag, input int got, input int exp_v);
    checks++;
    assert (got === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
  endtask

  task automatic clear_obs();
    valid_first = -1; valid_cnt = 0; data_first = -1;
    ferr_cnt = 0; ferr_at = -1; ovr_cnt = 0; ovr_at = -1;
    perr_cnt = 0; perr_at = -1; data_stop = -1; valid_stop = -1;
  endtask

  // Record outputs as they stand after edge k+e.
  task automatic observe(input int e);
    if (bus.out_valid) begin
      valid_cnt++;
      if (valid_first < 0) begin
        valid_first = e;
        data_first  = int'(bus.out_data);
      end
    end
    if (e == STOP_E) begin
      data_stop  = int'(bus.out_data);
      valid_stop = int'(bus.out_valid);
    end
    if (frame_err) begin ferr_cnt++; ferr_at = e; end
    if (overrun)   begin ovr_cnt++;  ovr_at  = e; end
`ifdef PARITY_CHECK_EN
    if (parity_err) begin perr_cnt++; perr_at = e; end
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b1;
    end
  endtask

  // Drive one frame; the value driven at negedge j is seen by edge k+j.
  task automatic run_frame(input logic [7:0] data, input logic par, input logic stop,
                           input int ready_at, input int tail, input logic tail_din);
    int total;
    int b;
    total = NBITS * BC + tail;
    clear_obs();
    for (int j = 0; j <= total; j++) begin
      @(negedge clk);
      if (j > 0) observe(j - 1);
      if (j < total) begin
        b = j / BC;
        if (b == 0)                       din = 1'b0;
        else if (b <= W)                  din = data[b-1];
        else if (P == 1 && b == W + 1)    din = par;
        else if (b == NBITS - 1)          din = stop;
        else                              din = tail_din;
        if (j == ready_at) bus.out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    logic [7:0] fr;
    int b;

    clr = 1'b1;
    din = 1'b1;
    bus.out_ready = 1'b1;
    #2;
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data",  int'(bus.out_data),  0);
    check("rst_ferr",  int'(frame_err),     0);
    check("rst_ovr",   int'(overrun),       0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    idle(4);

    // Basic frame 0xA5.
    run_frame(8'hA5, ^8'hA5, 1'b1, -1, 4, 1'b1);
    check("a5_latency", valid_first, STOP_E);
    check("a5_data",    data_first,  'hA5);
    check("a5_vcnt",    valid_cnt,   1);
    check("a5_ferr",    ferr_cnt,    0);
    check("a5_ovr",     ovr_cnt,     0);
`ifdef PARITY_CHECK_EN
    check("a5_perr",    perr_cnt,    0);
    // Wrong parity bit: word discarded, parity_err pulses on the stop edge.
    run_frame(8'hA5, ~(^8'hA5), 1'b1, -1, 4, 1'b1);
    check("par_vcnt",   valid_cnt,   0);
    check("par_pcnt",   perr_cnt,    1);
    check("par_pat",    perr_at,     STOP_E);
    check("par_ferr",   ferr_cnt,    0);
`endif

    // Stop bit 0, then din held low: no restart until din returns high.
    run_frame(8'h5A, ^8'h5A, 1'b0, -1, 48, 1'b0);
    check("ferr_vcnt",  valid_cnt,   0);
    check("ferr_cnt",   ferr_cnt,    1);
    check("ferr_at",    ferr_at,     STOP_E);
`ifdef PARITY_CHECK_EN
    check("ferr_pcnt",  perr_cnt,    0);
`endif
    idle(3);
    run_frame(8'h5A, ^8'h5A, 1'b1, -1, 4, 1'b1);
    check("after_ferr_lat",  valid_first, STOP_E);
    check("after_ferr_data", data_first,  'h5A);

    // One-cycle glitch is a false start.
    idle(2);
    clear_obs();
    @(negedge clk); din = 1'b0;
    @(negedge clk); din = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      @(negedge clk);
      observe(j);
    end
    check("glitch_vcnt", valid_cnt, 0);
    check("glitch_ferr", ferr_cnt,  0);
    check("glitch_ovr",  ovr_cnt,   0);
    run_frame(8'h81, ^8'h81, 1'b1, -1, 4, 1'b1);
    check("after_glitch_lat",  valid_first, STOP_E);
    check("after_glitch_data", data_first,  'h81);

    // Consumer stalled: second word overruns.
    bus.out_ready = 1'b0;
    idle(2);
    run_frame(8'h11, ^8'h11, 1'b1, -1, 4, 1'b1);
    check("ovr1_lat",  valid_first, STOP_E);
    check("ovr1_data", data_first,  'h11);
    check("ovr1_ovr",  ovr_cnt,     0);
    run_frame(8'h22, ^8'h22, 1'b1, -1, 4, 1'b1);
    check("ovr2_cnt",    ovr_cnt,    1);
    check("ovr2_at",     ovr_at,     STOP_E);
    check("ovr2_dstop",  data_stop,  'h11);
    check("ovr2_vstop",  valid_stop, 1);
    check("ovr2_hold",   int'(bus.out_data), 'h11);

    // Drain, then a same-edge handshake lets the second word in.
    bus.out_ready = 1'b1;
    idle(2);
    check("drain_valid", int'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    run_frame(8'h33, ^8'h33, 1'b1, -1, 4, 1'b1);
    check("hs1_data", data_first, 'h33);
    run_frame(8'h22, ^8'h22, 1'b1, STOP_E, 4, 1'b1);
    check("hs2_dstop", data_stop,  'h22);
    check("hs2_vstop", valid_stop, 1);
    check("hs2_ovr",   ovr_cnt,    0);

    // Reset mid-frame with a word held in the buffer.
    bus.out_ready = 1'b0;
    idle(2);
    run_frame(8'h77, ^8'h77, 1'b1, -1, 4, 1'b1);
    check("pre_clr_data", data_first, 'h77);
    fr = 8'h99;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      b = j / BC;
      din = (b == 0) ? 1'b0 : fr[b-1];
    end
    clr = 1'b1;
    #1;
    check("clr_valid", int'(bus.out_valid), 0);
    check("clr_data",  int'(bus.out_data),  0);
    check("clr_ferr",  int'(frame_err),     0);
    check("clr_ovr",   int'(overrun),       0);
    @(negedge clk);
    clr = 1'b0;
    din = 1'b1;
    bus.out_ready = 1'b1;
    idle(8);
    run_frame(8'h3C, ^8'h3C, 1'b1, -1, 4, 1'b1);
    check("post_clr_lat",  valid_first, STOP_E);
    check("post_clr_data", data_first,  'h3C);
    check("post_clr_ferr", ferr_cnt,    0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
